// File: rtl/rgs_rand_health_mon.sv
// Continuous health monitor for the randomizer's 2-bit stream: repetition count and adaptive proportion tests.
// Define RGS_HEALTH_STATS_EN to add the o_max_run longest-run statistic output.
//
// APT state | meaning
// ----------+---------------------------------------------------------
// ST_START  | waiting for the first sample of a window (becomes ref_sym)
// ST_COLLECT| counting window samples and reference-symbol hits
module rgs_rand_health_mon #(
    parameter int RCT_CUTOFF = 8,
    parameter int APT_WINDOW = 64,
    parameter int APT_CUTOFF = 40
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_en,
    input  logic [1:0] i_r,
    input  logic       i_clr,
    output logic       o_rct_fail,
    output logic       o_apt_fail,
    output logic       o_win_done,
`ifdef RGS_HEALTH_STATS_EN
    output logic [7:0] o_max_run,
`endif
    output logic       o_healthy
);

    localparam logic [0:0] ST_START   = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;

    localparam logic [7:0] RCT_CUT = 8'(RCT_CUTOFF);
    localparam logic [7:0] APT_WIN = 8'(APT_WINDOW);
    localparam logic [7:0] APT_CUT = 8'(APT_CUTOFF);

    logic [0:0] state;
    logic [1:0] last_sym;
    logic [7:0] run;
    logic [1:0] ref_sym;
    logic [7:0] ref_cnt;
    logic [7:0] win_cnt;
    logic       window_seen;

    logic [7:0] run_nxt;
    logic [1:0] ref_sym_nxt;
    logic [7:0] ref_cnt_nxt;
    logic [7:0] win_cnt_nxt;
    logic       win_end;
    logic       rct_nxt;
    logic       apt_nxt;
    logic       seen_nxt;

    always_comb begin
        run_nxt     = 8'd1;
        ref_sym_nxt = ref_sym;
        ref_cnt_nxt = ref_cnt;
        win_cnt_nxt = win_cnt;

        // run==0 marks "no sample since reset/clear", so the first sample starts a run of 1
        if (run != 8'd0 && i_r == last_sym) begin
            run_nxt = (run == 8'hff) ? run : run + 8'd1;
        end

        if (state == ST_START) begin
            ref_sym_nxt = i_r;
            ref_cnt_nxt = 8'd1;
            win_cnt_nxt = 8'd1;
        end else begin
            win_cnt_nxt = win_cnt + 8'd1;
            ref_cnt_nxt = ref_cnt + {7'd0, (i_r == ref_sym)};
        end

        win_end  = (win_cnt_nxt == APT_WIN);
        rct_nxt  = o_rct_fail | (run_nxt >= RCT_CUT);
        apt_nxt  = o_apt_fail | (ref_cnt_nxt >= APT_CUT);
        seen_nxt = window_seen | win_end;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= ST_START;
            last_sym    <= 2'd0;
            run         <= 8'd0;
            ref_sym     <= 2'd0;
            ref_cnt     <= 8'd0;
            win_cnt     <= 8'd0;
            window_seen <= 1'b0;
            o_rct_fail  <= 1'b0;
            o_apt_fail  <= 1'b0;
            o_win_done  <= 1'b0;
            o_healthy   <= 1'b0;
        end else if (i_clr) begin
            state       <= ST_START;
            last_sym    <= 2'd0;
            run         <= 8'd0;
            ref_sym     <= 2'd0;
            ref_cnt     <= 8'd0;
            win_cnt     <= 8'd0;
            window_seen <= 1'b0;
            o_rct_fail  <= 1'b0;
            o_apt_fail  <= 1'b0;
            o_win_done  <= 1'b0;
            o_healthy   <= 1'b0;
        end else if (i_en) begin
            state       <= win_end ? ST_START : ST_COLLECT;
            last_sym    <= i_r;
            run         <= run_nxt;
            ref_sym     <= ref_sym_nxt;
            ref_cnt     <= ref_cnt_nxt;
            win_cnt     <= win_cnt_nxt;
            window_seen <= seen_nxt;
            o_rct_fail  <= rct_nxt;
            o_apt_fail  <= apt_nxt;
            o_win_done  <= win_end;
            o_healthy   <= seen_nxt & ~rct_nxt & ~apt_nxt;
        end else begin
            o_win_done  <= 1'b0;
        end
    end

`ifdef RGS_HEALTH_STATS_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_max_run <= 8'd0;
        end else if (i_clr) begin
            o_max_run <= 8'd0;
        end else if (i_en && run_nxt > o_max_run) begin
            o_max_run <= run_nxt;
        end
    end
`endif

endmodule

// File: doc/rgs_rand_health_mon.md
Name: rgs_rand_health_mon

Overview:
- Consumer end of the randomizer's 2-bit output stream `o_r`.
- Runs continuous health tests on every sample it accepts: a repetition count test (RCT) and an adaptive proportion test (APT).
- Raises sticky failure flags and a healthy indication for top-level status pins.
- Placed beside the randomizer instance in `tt_um_rgs_randomizer`. Its `i_r` and `i_en` are driven by the randomizer's `o_r` and the same enable.

Parameters:
- RCT_CUTOFF, 8: consecutive identical samples that trigger an RCT failure (valid range 2..255).
- APT_WINDOW, 64: samples per APT window (valid range 2..255).
- APT_CUTOFF, 40: count of the window's reference symbol that triggers an APT failure (valid range 2..APT_WINDOW).

Ports:
- i_clk  input  1  clock.
- i_reset  input  1  asynchronous, active-high reset.
- i_en  input  1  sample qualifier; a sample is accepted on an i_clk rising edge when i_en=1.
- i_r  input  2  random symbol from the randomizer.
- i_clr  input  1  synchronous clear of all test state and flags; has priority over i_en.
- o_rct_fail  output  1  sticky RCT failure.
- o_apt_fail  output  1  sticky APT failure.
- o_win_done  output  1  one-cycle pulse when an APT window completes.
- o_healthy  output  1  at least one full window has completed and no failure flag is set.

Behaviour:
- All outputs are registered. Every output is 0 on reset and after i_clr.
- Latency: the effect of an accepted sample is visible in the cycle after the accepting edge.
- i_reset is asynchronous and clears everything immediately, including mid-window.
- i_clr=1 gives the same resulting state as reset, applied on the clock edge. A sample presented in the same cycle as i_clr is discarded.
- When i_en=0, nothing changes and o_win_done=0. Gaps in i_en do not break runs or windows.
- RCT:
  - Holds `last_sym` and `run` (8 bits, saturating at 255).
  - First accepted sample after reset or clear: run=1.
  - A later accepted sample equal to last_sym increments run; a different sample sets run=1.
  - Set o_rct_fail when the updated run is >= RCT_CUTOFF.
- APT FSM, states START and COLLECT:
  - START: on an accepted sample, set ref_sym=i_r, ref_cnt=1, win_cnt=1, then go to COLLECT.
  - COLLECT: on an accepted sample, win_cnt+1; ref_cnt+1 if i_r==ref_sym.
  - Set o_apt_fail when the updated ref_cnt is >= APT_CUTOFF.
  - When the updated win_cnt == APT_WINDOW: pulse o_win_done, set window_seen, return to START. The next accepted sample starts a new window; there is no overlap between windows.
- Counters are 8 bits wide. ref_cnt and win_cnt cannot exceed APT_WINDOW.
- Fail flags are sticky. Only reset or i_clr clears them, and they never self-clear. Testing continues after a failure.
- Both failures on the same sample: both flags are set in the same cycle.
- o_healthy = window_seen AND NOT o_rct_fail AND NOT o_apt_fail, registered.
  - It rises in the same cycle as the first o_win_done pulse if no failure has occurred.
  - It falls in the same cycle as any failure flag rises.
- A failure on the last sample of a window: that o_win_done pulse still occurs, and o_healthy stays 0.

Optional Feature:
- Macro: RGS_HEALTH_STATS_EN.
- Defined: adds output port o_max_run [7:0], the longest run observed since reset or clear.
  - Registered and saturating at 255.
  - Updated in the same cycle as run.
  - Reset and clear value 0.
- Not defined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Cycle 0,1,2,3 with i_en=1 for 64 samples -> o_win_done pulses exactly once, the cycle after sample 64; o_healthy=1 from that cycle; both fail flags 0.
- 7 consecutive 2'b10 samples, then 2'b01 -> no o_rct_fail. Then 8 consecutive 2'b11 -> o_rct_fail=1 the cycle after the 8th sample, o_healthy=0, and the flag stays 1 for 100 further alternating samples.
- Window of 0,0,0,1 repeated (run max 3, symbol 0 counted 40 times by sample 53) -> o_apt_fail=1 the cycle after sample 53; o_rct_fail stays 0.
- Same stream as the first scenario, with i_en deasserted for 5 cycles between every two samples -> results identical to the first scenario; o_win_done=0 during the gaps.
- Assert i_reset asynchronously at sample 30 of a window, then feed 64 alternating samples -> all outputs 0 immediately on reset; o_win_done occurs after sample 64 of the new stream, not sample 34.
- With o_rct_fail=1, pulse i_clr for one cycle alongside i_en=1 -> that sample is ignored; flags 0 next cycle; a fresh 64-sample window then gives o_healthy=1. With RGS_HEALTH_STATS_EN, o_max_run reads 8 before the clear and 0 after it.
